// File: rtl/u8f_pkg.sv
// Shared types and widths for the u8-to-float burst streamer.
package u8f_pkg;

  localparam int unsigned FLOAT_W  = 32;
  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} u8f_state_t;

  // One output buffer entry: converted word plus its last-beat flag.
  typedef struct packed {
    logic               last;
    logic [FLOAT_W-1:0] data;
  } u8f_beat_t;

endpackage

// File: rtl/u8_float_stream_ctrl_if.sv
// Sample-in / float-out valid-ready stream pair of the burst streamer.
interface u8_float_stream_ctrl_if;
  import u8f_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [SAMPLE_W-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [FLOAT_W-1:0]  out_data;
  logic                out_last;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/u8f_skid_buf.sv
// Two-entry valid/ready output buffer with occupancy count and synchronous flush.
module u8f_skid_buf
  import u8f_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      flush,
  input  logic      push,
  input  u8f_beat_t push_data,
  input  logic      pop_ready,
  output logic      pop_valid,
  output u8f_beat_t pop_data,
  output logic [1:0] count
);

  u8f_beat_t  ent0, ent1;
  logic [1:0] cnt;
  logic       vld;
  logic       pop_c;
  logic       push_ok_c;

  assign pop_c     = vld && pop_ready;
  assign push_ok_c = push && ((cnt != 2'd2) || pop_c);

  // ent0 is always the head; it only changes when empty or on a pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
      vld  <= 1'b0;
    end else if (flush) begin
      cnt <= '0;
      vld <= 1'b0;
    end else begin
      case ({push_ok_c, pop_c})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= push_data;
          else             ent1 <= push_data;
          cnt <= cnt + 2'd1;
          vld <= 1'b1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
          vld  <= (cnt == 2'd2);
        end
        2'b11: begin
          if (cnt == 2'd2) begin
            ent0 <= ent1;
            ent1 <= push_data;
          end else begin
            ent0 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign pop_valid = vld;
  assign pop_data  = ent0;
  assign count     = cnt;

endmodule

// File: rtl/uint_to_float.sv
// Combinational 8-bit unsigned to IEEE-754 single, scaled by 1/256.
module uint_to_float (
  input  logic [7:0]  u,
  output logic [31:0] f_c
);

  logic [2:0]  msb;
  logic [7:0]  expo;
  logic [22:0] man;

  // Exponent is 127 - 8 + msb; mantissa drops the hidden leading one.
  always_comb begin
    msb = '0;
    for (int i = 0; i < 8; i++) begin
      if (u[i]) msb = 3'(i);
    end
    expo = 8'(119) + 8'(msb);
    man  = 23'(u) << (5'd23 - 5'(msb));
    f_c  = (u == '0) ? '0 : {1'b0, expo, man};
  end

endmodule

// File: rtl/u8_float_stream_ctrl.sv
// Moves length-bounded bursts of 8-bit samples through uint_to_float into a
// registered, backpressure-safe float stream with last, done, abort and beat count.
module u8_float_stream_ctrl
  import u8f_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic                   abort,
  u8_float_stream_ctrl_if.slave  strm,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_W-1:0]       beat_cnt
);

  u8f_state_t       state, state_nxt;
  logic [LEN_W-1:0] remaining;
  logic [1:0]       buf_count;
  logic             head_valid;
  u8f_beat_t        head;
  u8f_beat_t        push_beat_c;
  logic [FLOAT_W-1:0] conv_c;
  logic             accept_c;
  logic             deliver_c;
  logic             start_ok_c;
  logic             drain_empty_c;

  // in_ready depends only on registered state, never on in_valid.
  assign strm.in_ready = (state == RUN) && (remaining != '0) && (buf_count < 2'd2);
  assign accept_c      = strm.in_valid && strm.in_ready;
  assign deliver_c     = head_valid && strm.out_ready;
  assign start_ok_c    = start && !abort;
  assign drain_empty_c = (buf_count == 2'd0) || ((buf_count == 2'd1) && deliver_c);

  uint_to_float u_conv (
    .u   (strm.in_data),
    .f_c (conv_c)
  );

  assign push_beat_c = {(remaining == LEN_W'(1)), conv_c};

  u8f_skid_buf u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (abort),
    .push      (accept_c),
    .push_data (push_beat_c),
    .pop_ready (strm.out_ready),
    .pop_valid (head_valid),
    .pop_data  (head),
    .count     (buf_count)
  );

  assign strm.out_valid = head_valid;
  assign strm.out_data  = head.data;
  assign strm.out_last  = head.last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Abort overrides every transition, including a same-cycle start.
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (len == '0) ? DONE : RUN;
        RUN:     if (accept_c && (remaining == LEN_W'(1))) state_nxt = DRAIN;
        DRAIN:   if (drain_empty_c) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they track state exactly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      beat_cnt  <= '0;
    end else begin
      busy <= (state_nxt != IDLE);
      done <= (state_nxt == DONE);

      if (abort)                              remaining <= '0;
      else if ((state == IDLE) && start)      remaining <= len;
      else if (accept_c)                      remaining <= remaining - LEN_W'(1);

      if ((state == IDLE) && start_ok_c)      beat_cnt <= '0;
      else if (deliver_c)                     beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

endmodule
